skin_segment_streamer: RTL and testbench
========================================

// Module: skin_segment_streamer
// PURPOSE
//  Front end of the gesture pipeline. Accepts a raster CbCr pixel stream and classifies each pixel as skin or not.
//  Cleans each row with a 3-tap horizontal majority filter.
//  Emits the 1-bit object_image stream, with row/col tags, that palm identification and later stages consume.
// PARAMETERS
//  IMAGE_WIDTH   120  pixels per row (2..255)
//  IMAGE_HEIGHT  160  rows per frame (1..255)
//  FILTER_EN     1    1: majority filter; 0: raw classification, same latency
// PORTS
//  clk           in   1  sole clock
//  rst           in   1  synchronous, active-high reset
//  start         in   1  1-cycle pulse; begins a frame when IDLE
//  cb_min/cb_max in   8  inclusive Cb skin bounds
//  cr_min/cr_max in   8  inclusive Cr skin bounds
//  pix_valid     in   1  upstream pixel valid
//  pix_ready     out  1  block accepts pixel this cycle
//  pix_cb/pix_cr in   8  pixel chroma
//  obj_valid     out  1  object_image valid
//  obj_ready     in   1  downstream accepts
//  object_image  out  1  1 = hand pixel
//  obj_row       out  8  row index of emitted pixel
//  obj_col       out  8  col index of emitted pixel
//  obj_sof       out  1  emitted pixel is (0,0)
//  obj_eol       out  1  emitted pixel is col IMAGE_WIDTH-1
//  frame_done    out  1  1-cycle pulse after last pixel handshakes out
// BEHAVIOUR
//  - Reset: every output 0 (pix_ready=0, obj_valid=0); state IDLE; counters and window cleared.
//  - Classification: skin = (cb_min<=cb<=cb_max) && (cr_min<=cr<=cr_max), unsigned, combinational at input.
//    Any min>max pair gives all 0.
//  - Handshake: input transfer on pix_valid&&pix_ready; output transfer on obj_valid&&obj_ready.
//  - Output register holds stable until taken.
//  - pix_ready = (state==RUN) && (!obj_valid || obj_ready).
//  - Window: a = class(col k-2), b = class(col k-1); x = incoming class(col k).
//  - On accept of col k>=1: emit col k-1 = maj(k-1==0 ? 0 : a, b, x); then shift a<=b, b<=x.
//  - On accept of col 0: store only, no emit.
//  - Latency: pixel col k appears on obj_* the cycle after col k+1 is accepted.
//    For col IMAGE_WIDTH-1 it appears on the FLUSH emit.
//  - Row edges: missing neighbour = 0. Window never spans rows.
//  - FSM:
//    - IDLE: start -> RUN; row=col=0.
//    - RUN: on accept of col IMAGE_WIDTH-1 -> FLUSH.
//    - FLUSH: pix_ready=0. When the output slot is free, emit col W-1 = maj(b, x, 0). Then:
//      - last row -> DONE;
//      - else -> RUN with row+1, col=0.
//    - DONE: wait for the final obj handshake; pulse frame_done; -> IDLE.
//  - start while not IDLE is ignored.
//  - obj_ready held low stalls indefinitely with no loss or duplication.
//  - pix_valid low mid-row simply pauses the window.
//  - Output order is strictly raster; exactly W*H outputs per frame.
//  - obj_sof and obj_eol are aligned with their pixel.
//  - rst mid-frame: the next cycle matches reset state; the partial frame is discarded and no frame_done is issued.
//  - Counters are 8 bits. col wraps to 0 at W-1; no counter overflow within legal parameters.
// STRUCTURE
//  - gesture_defs.vh (shared): IMAGE_WIDTH/HEIGHT defaults, FSM state encodings (IDLE/RUN/FLUSH/DONE), default skin bounds (Cb 77..127, Cr 133..173).
//  - Sub-module skin_classify: combinational range compare, reused by calibration logic.
//  - Majority, window and FSM live in this block.
// TESTING
//  1. All pixels Cb=100/Cr=150, obj_ready=1 -> 19200 outputs, all 1; obj_sof once; 160 obj_eol; one frame_done.
//  2. Single skin pixel at (5,10), FILTER_EN=1 -> all outputs 0. Same stimulus with FILTER_EN=0 -> exactly one 1, at row 5 col 10.
//  3. Bounds: (cb=77, cr=173) -> 1; (cb=76, cr=150) -> 0; (cb=128, cr=150) -> 0.
//  4. obj_ready toggles 1,0,1,0 and pix_valid is random -> output matches reference model bit-for-bit.
//     pix_ready never high while obj_valid && !obj_ready.
//  5. Row end skin at cols 118,119 only -> col117=0, col118=1, col119=1 (maj(1,1,0)); next row col0 is unaffected.
//  6. rst at row 37 col 50 -> next cycle obj_valid=0, pix_ready=0. Then start -> first output tagged row 0 col 0 with obj_sof=1.

Source files
------------

// File: rtl/skin_segment_streamer_pkg.sv
// Shared definitions for the skin segmentation front end: frame geometry defaults,
// FSM state encoding, default skin chroma bounds and the 3-input majority helper.
package skin_segment_streamer_pkg;

  localparam int unsigned DefaultImageWidth  = 120;
  localparam int unsigned DefaultImageHeight = 160;

  localparam logic [7:0] DefaultCbMin = 8'd77;
  localparam logic [7:0] DefaultCbMax = 8'd127;
  localparam logic [7:0] DefaultCrMin = 8'd133;
  localparam logic [7:0] DefaultCrMax = 8'd173;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRun   = 2'd1,
    StFlush = 2'd2,
    StDone  = 2'd3
  } state_e;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/skin_segment_streamer_if.sv
// Pixel-in / object-image-out stream bundle. The master drives pixels and accepts
// object pixels; the slave (the streamer) does the reverse.
interface skin_segment_streamer_if;
  logic       pix_valid;
  logic       pix_ready;
  logic [7:0] pix_cb;
  logic [7:0] pix_cr;
  logic       obj_valid;
  logic       obj_ready;
  logic       object_image;
  logic [7:0] obj_row;
  logic [7:0] obj_col;
  logic       obj_sof;
  logic       obj_eol;

  modport master (
    output pix_valid, pix_cb, pix_cr, obj_ready,
    input  pix_ready, obj_valid, object_image, obj_row, obj_col, obj_sof, obj_eol
  );

  modport slave (
    input  pix_valid, pix_cb, pix_cr, obj_ready,
    output pix_ready, obj_valid, object_image, obj_row, obj_col, obj_sof, obj_eol
  );
endinterface

// File: rtl/skin_classify.sv
// Inclusive unsigned CbCr range compare; an inverted (min > max) pair never matches.
module skin_classify (
  input  logic [7:0] cb,
  input  logic [7:0] cr,
  input  logic [7:0] cb_min,
  input  logic [7:0] cb_max,
  input  logic [7:0] cr_min,
  input  logic [7:0] cr_max,
  output logic       skin
);

  assign skin = (cb >= cb_min) && (cb <= cb_max) && (cr >= cr_min) && (cr <= cr_max);

endmodule

// File: rtl/skin_segment_streamer.sv
// Skin segmentation front end: classifies raster CbCr pixels, cleans each row with a
// 3-tap majority filter and emits a row/col-tagged 1-bit object stream.
module skin_segment_streamer
  import skin_segment_streamer_pkg::*;
#(
  parameter int unsigned IMAGE_WIDTH  = DefaultImageWidth,
  parameter int unsigned IMAGE_HEIGHT = DefaultImageHeight,
  parameter bit          FILTER_EN    = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [7:0]             cb_min,
  input  logic [7:0]             cb_max,
  input  logic [7:0]             cr_min,
  input  logic [7:0]             cr_max,
  output logic                   frame_done,
  skin_segment_streamer_if.slave strm
);

  localparam logic [7:0] LastCol = 8'(IMAGE_WIDTH - 1);
  localparam logic [7:0] LastRow = 8'(IMAGE_HEIGHT - 1);

  state_e     state_q, state_d;
  logic [7:0] row_q, row_d;
  logic [7:0] col_q, col_d;
  // win_a = class(col k-2), win_b = class(col k-1) relative to the next incoming col k.
  logic       win_a_q, win_a_d;
  logic       win_b_q, win_b_d;
  logic       obj_valid_q, obj_valid_d;
  logic       obj_bit_q, obj_bit_d;
  logic [7:0] obj_row_q, obj_row_d;
  logic [7:0] obj_col_q, obj_col_d;
  logic       obj_sof_q, obj_sof_d;
  logic       obj_eol_q, obj_eol_d;
  logic       frame_done_q, frame_done_d;

  logic pix_class;
  logic slot_free;
  logic pix_ready;
  logic pix_accept;
  logic obj_take;
  logic run_bit;
  logic flush_bit;

  skin_classify u_classify (
    .cb     (strm.pix_cb),
    .cr     (strm.pix_cr),
    .cb_min (cb_min),
    .cb_max (cb_max),
    .cr_min (cr_min),
    .cr_max (cr_max),
    .skin   (pix_class)
  );

  assign slot_free  = !obj_valid_q || strm.obj_ready;
  assign pix_ready  = (state_q == StRun) && slot_free;
  assign pix_accept = pix_ready && strm.pix_valid;
  assign obj_take   = obj_valid_q && strm.obj_ready;

  // win_a is cleared on col 0, so col 0's missing left neighbour reads as 0.
  assign run_bit   = FILTER_EN ? maj3(win_a_q, win_b_q, pix_class) : win_b_q;
  // After the last accept the window holds cols W-2, W-1; right neighbour is 0.
  assign flush_bit = FILTER_EN ? (win_a_q & win_b_q) : win_b_q;

  // Next-state: frame FSM, window shift and output slot load/release.
  always_comb begin
    state_d      = state_q;
    row_d        = row_q;
    col_d        = col_q;
    win_a_d      = win_a_q;
    win_b_d      = win_b_q;
    obj_valid_d  = obj_valid_q && !strm.obj_ready;
    obj_bit_d    = obj_bit_q;
    obj_row_d    = obj_row_q;
    obj_col_d    = obj_col_q;
    obj_sof_d    = obj_sof_q;
    obj_eol_d    = obj_eol_q;
    frame_done_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StRun;
          row_d   = 8'd0;
          col_d   = 8'd0;
        end
      end
      StRun: begin
        if (pix_accept) begin
          win_a_d = (col_q == 8'd0) ? 1'b0 : win_b_q;
          win_b_d = pix_class;
          if (col_q != 8'd0) begin
            obj_valid_d = 1'b1;
            obj_bit_d   = run_bit;
            obj_row_d   = row_q;
            obj_col_d   = col_q - 8'd1;
            obj_sof_d   = (row_q == 8'd0) && (col_q == 8'd1);
            obj_eol_d   = 1'b0;
          end
          if (col_q == LastCol) begin
            col_d   = 8'd0;
            state_d = StFlush;
          end else begin
            col_d = col_q + 8'd1;
          end
        end
      end
      StFlush: begin
        if (slot_free) begin
          obj_valid_d = 1'b1;
          obj_bit_d   = flush_bit;
          obj_row_d   = row_q;
          obj_col_d   = LastCol;
          obj_sof_d   = 1'b0;
          obj_eol_d   = 1'b1;
          if (row_q == LastRow) begin
            state_d = StDone;
          end else begin
            row_d   = row_q + 8'd1;
            col_d   = 8'd0;
            state_d = StRun;
          end
        end
      end
      StDone: begin
        if (obj_take) begin
          frame_done_d = 1'b1;
          state_d      = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      row_q        <= 8'd0;
      col_q        <= 8'd0;
      win_a_q      <= 1'b0;
      win_b_q      <= 1'b0;
      obj_valid_q  <= 1'b0;
      obj_bit_q    <= 1'b0;
      obj_row_q    <= 8'd0;
      obj_col_q    <= 8'd0;
      obj_sof_q    <= 1'b0;
      obj_eol_q    <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      row_q        <= row_d;
      col_q        <= col_d;
      win_a_q      <= win_a_d;
      win_b_q      <= win_b_d;
      obj_valid_q  <= obj_valid_d;
      obj_bit_q    <= obj_bit_d;
      obj_row_q    <= obj_row_d;
      obj_col_q    <= obj_col_d;
      obj_sof_q    <= obj_sof_d;
      obj_eol_q    <= obj_eol_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign strm.pix_ready    = pix_ready;
  assign strm.obj_valid    = obj_valid_q;
  assign strm.object_image = obj_bit_q;
  assign strm.obj_row      = obj_row_q;
  assign strm.obj_col      = obj_col_q;
  assign strm.obj_sof      = obj_sof_q;
  assign strm.obj_eol      = obj_eol_q;
  assign frame_done        = frame_done_q;

endmodule

// File: tb/tb_skin_segment_streamer.sv
// Bench for skin_segment_streamer: a filtered and a raw instance run in lockstep on the
// same stimulus; a frame model pushes expected outputs to a queue that the monitor pops.
module tb_skin_segment_streamer;
  import skin_segment_streamer_pkg::*;

  localparam int W = 120;
  localparam int H = 160;

  typedef struct packed {
    logic [7:0] row;
    logic [7:0] col;
    logic       filt;
    logic       raw;
    logic       sof;
    logic       eol;
  } exp_t;

  typedef struct {
    int         row;
    int         col;
    logic [7:0] cb;
    logic [7:0] cr;
    logic       filt;
    logic       raw;
  } vec_t;

  logic       clk;
  logic       rst;
  logic       start;
  logic       pix_valid;
  logic [7:0] pix_cb;
  logic [7:0] pix_cr;
  logic       obj_ready;
  logic       toggle;
  logic       done_f_sig;
  logic       done_r_sig;

  skin_segment_streamer_if if_f ();
  skin_segment_streamer_if if_r ();

  assign if_f.pix_valid = pix_valid;
  assign if_f.pix_cb    = pix_cb;
  assign if_f.pix_cr    = pix_cr;
  assign if_f.obj_ready = obj_ready;
  assign if_r.pix_valid = pix_valid;
  assign if_r.pix_cb    = pix_cb;
  assign if_r.pix_cr    = pix_cr;
  assign if_r.obj_ready = obj_ready;

  skin_segment_streamer #(.IMAGE_WIDTH(W), .IMAGE_HEIGHT(H), .FILTER_EN(1'b1)) dut_f (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .cb_min     (DefaultCbMin),
    .cb_max     (DefaultCbMax),
    .cr_min     (DefaultCrMin),
    .cr_max     (DefaultCrMax),
    .frame_done (done_f_sig),
    .strm       (if_f)
  );

  skin_segment_streamer #(.IMAGE_WIDTH(W), .IMAGE_HEIGHT(H), .FILTER_EN(1'b0)) dut_r (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .cb_min     (DefaultCbMin),
    .cb_max     (DefaultCbMax),
    .cr_min     (DefaultCrMin),
    .cr_max     (DefaultCrMax),
    .frame_done (done_r_sig),
    .strm       (if_r)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] img_cb [H][W];
  logic [7:0] img_cr [H][W];
  bit         cls    [H][W];
  bit         got_f  [H][W];
  bit         got_r  [H][W];
  exp_t       exp_q  [$];
  vec_t       vecs   [12];

  int    n_checks, n_pass;
  int    n_out, ones_f, ones_r, n_sof, n_eol, done_f, done_r, sb_err, ready_viol;
  int    first_row, first_col, first_sof;
  string sb_msg;
  exp_t  mon_e;

  task automatic check(input string name, input int got, input int want);
    n_checks++;
    if (got == want) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, got, want);
  endtask

  task automatic finish_report();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  endtask

  function automatic bit in_skin(input logic [7:0] cb, input logic [7:0] cr);
    return (cb >= DefaultCbMin) && (cb <= DefaultCbMax) &&
           (cr >= DefaultCrMin) && (cr <= DefaultCrMax);
  endfunction

  // Values clustered on the bound edges so both classes occur densely.
  function automatic logic [7:0] pick(input logic [7:0] lo, input logic [7:0] hi);
    case ($urandom_range(0, 5))
      0:       return 8'(lo - 8'd1);
      1:       return lo;
      2:       return hi;
      3:       return 8'(hi + 8'd1);
      default: return 8'((int'(lo) + int'(hi)) / 2);
    endcase
  endfunction

  task automatic fill_image(input int mode);
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        case (mode)
          0: begin img_cb[r][c] = 8'd100; img_cr[r][c] = 8'd150; end
          1: begin
            img_cb[r][c] = (r == 5 && c == 10) ? 8'd100 : 8'd0;
            img_cr[r][c] = (r == 5 && c == 10) ? 8'd150 : 8'd0;
          end
          2: begin img_cb[r][c] = 8'd0; img_cr[r][c] = 8'd0; end
          default: begin
            if (r == 3 || r == 4 || r == 7 || r == 9) begin
              img_cb[r][c] = 8'd0;
              img_cr[r][c] = 8'd0;
            end else begin
              img_cb[r][c] = pick(DefaultCbMin, DefaultCbMax);
              img_cr[r][c] = pick(DefaultCrMin, DefaultCrMax);
            end
          end
        endcase
      end
    end
    if (mode == 3) begin
      for (int i = 0; i < 12; i++) begin
        img_cb[vecs[i].row][vecs[i].col] = vecs[i].cb;
        img_cr[vecs[i].row][vecs[i].col] = vecs[i].cr;
      end
    end
  endtask

  // Frame reference model: neighbours outside the row are 0.
  task automatic push_frame();
    exp_t e;
    bit   l, m, rn;
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) cls[r][c] = in_skin(img_cb[r][c], img_cr[r][c]);
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        l      = (c > 0) ? cls[r][c-1] : 1'b0;
        m      = cls[r][c];
        rn     = (c < W - 1) ? cls[r][c+1] : 1'b0;
        e.row  = 8'(r);
        e.col  = 8'(c);
        e.filt = (l & m) | (m & rn) | (l & rn);
        e.raw  = m;
        e.sof  = (r == 0 && c == 0);
        e.eol  = (c == W - 1);
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic clear_stats();
    n_out = 0; ones_f = 0; ones_r = 0; n_sof = 0; n_eol = 0; done_f = 0; done_r = 0;
    sb_err = 0; ready_viol = 0; sb_msg = "";
    first_row = -1; first_col = -1; first_sof = -1;
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) begin got_f[r][c] = 1'b0; got_r[r][c] = 1'b0; end
  endtask

  // Streams the image; returns just before presenting (stop_r, stop_c) if reached.
  task automatic drive_frame(input bit rnd, input int stop_r, input int stop_c,
                             input int start_r, output bit ok);
    bit acc;
    int waited;
    ok = 1'b1;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    for (int r = 0; r < H; r++) begin
      toggle = rnd && (r < 64);
      for (int c = 0; c < W; c++) begin
        if (r == stop_r && c == stop_c) begin
          pix_valid = 1'b0;
          return;
        end
        pix_cb = img_cb[r][c];
        pix_cr = img_cr[r][c];
        if (r == start_r && c == 7) start = 1'b1;
        acc    = 1'b0;
        waited = 0;
        while (!acc) begin
          pix_valid = rnd ? ($urandom_range(0, 7) != 0) : 1'b1;
          @(negedge clk);
          acc = pix_valid && if_f.pix_ready;
          @(posedge clk); #1;
          start = 1'b0;
          waited++;
          if (waited > 1000) begin
            ok        = 1'b0;
            pix_valid = 1'b0;
            return;
          end
        end
      end
    end
    pix_valid = 1'b0;
    toggle    = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (done_f == 0 && n < 2000) begin
      @(posedge clk);
      n++;
    end
    repeat (4) @(posedge clk);
    #1;
    check({name, "_frame_done_f"}, done_f, 1);
    check({name, "_frame_done_r"}, done_r, 1);
    check({name, "_scoreboard_errs"}, sb_err, 0);
    if (sb_err != 0) $display("FAIL %s_first_scoreboard_diff: %s", name, sb_msg);
    check({name, "_missing_outputs"}, exp_q.size(), 0);
    check({name, "_out_count"}, n_out, W * H);
  endtask

  initial begin
    obj_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      obj_ready = toggle ? ~obj_ready : 1'b1;
    end
  end

  // Monitor: sample mid-cycle so handshake values match the coming edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (if_f.pix_ready && if_f.obj_valid && !if_f.obj_ready) ready_viol++;
      if (if_r.pix_ready && if_r.obj_valid && !if_r.obj_ready) ready_viol++;
      if (if_f.obj_valid !== if_r.obj_valid || if_f.pix_ready !== if_r.pix_ready) begin
        sb_err++;
        if (sb_msg == "") sb_msg = "filtered and raw instances out of step";
      end
      if (if_f.obj_valid && if_f.obj_ready) begin
        if (n_out == 0) begin
          first_row = int'(if_f.obj_row);
          first_col = int'(if_f.obj_col);
          first_sof = int'(if_f.obj_sof);
        end
        n_out++;
        ones_f += int'(if_f.object_image);
        ones_r += int'(if_r.object_image);
        n_sof  += int'(if_f.obj_sof);
        n_eol  += int'(if_f.obj_eol);
        if (exp_q.size() == 0) begin
          sb_err++;
          if (sb_msg == "")
            sb_msg = $sformatf("unexpected output row %0d col %0d", if_f.obj_row, if_f.obj_col);
        end else begin
          mon_e = exp_q.pop_front();
          got_f[int'(mon_e.row)][int'(mon_e.col)] = if_f.object_image;
          got_r[int'(mon_e.row)][int'(mon_e.col)] = if_r.object_image;
          if (if_f.obj_row !== mon_e.row || if_f.obj_col !== mon_e.col ||
              if_r.obj_row !== mon_e.row || if_r.obj_col !== mon_e.col ||
              if_f.object_image !== mon_e.filt || if_r.object_image !== mon_e.raw ||
              if_f.obj_sof !== mon_e.sof || if_f.obj_eol !== mon_e.eol) begin
            sb_err++;
            if (sb_msg == "")
              sb_msg = $sformatf(
                "got r%0d c%0d f%0d raw%0d sof%0d eol%0d, want r%0d c%0d f%0d raw%0d sof%0d eol%0d",
                if_f.obj_row, if_f.obj_col, if_f.object_image, if_r.object_image,
                if_f.obj_sof, if_f.obj_eol, mon_e.row, mon_e.col, mon_e.filt, mon_e.raw,
                mon_e.sof, mon_e.eol);
          end
        end
      end
      done_f += int'(done_f_sig);
      done_r += int'(done_r_sig);
    end
  end

  initial begin
    bit ok;
    // {row, col, cb, cr, filtered, raw}; the rows used are background elsewhere.
    vecs[0]  = '{7,  20,  8'd77,  8'd173, 1'b0, 1'b1};
    vecs[1]  = '{7,  40,  8'd76,  8'd150, 1'b0, 1'b0};
    vecs[2]  = '{7,  60,  8'd128, 8'd150, 1'b0, 1'b0};
    vecs[3]  = '{7,  80,  8'd127, 8'd133, 1'b0, 1'b1};
    vecs[4]  = '{7,  100, 8'd100, 8'd174, 1'b0, 1'b0};
    vecs[5]  = '{3,  117, 8'd0,   8'd0,   1'b0, 1'b0};
    vecs[6]  = '{3,  118, 8'd100, 8'd150, 1'b1, 1'b1};
    vecs[7]  = '{3,  119, 8'd100, 8'd150, 1'b1, 1'b1};
    vecs[8]  = '{4,  0,   8'd0,   8'd0,   1'b0, 1'b0};
    vecs[9]  = '{9,  0,   8'd100, 8'd150, 1'b1, 1'b1};
    vecs[10] = '{9,  1,   8'd100, 8'd150, 1'b1, 1'b1};
    vecs[11] = '{9,  2,   8'd0,   8'd0,   1'b0, 1'b0};

    n_checks = 0; n_pass = 0;
    rst = 1'b1; start = 1'b0; pix_valid = 1'b0; pix_cb = 8'd0; pix_cr = 8'd0;
    toggle = 1'b0;
    clear_stats();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_obj_valid", int'(if_f.obj_valid), 0);
    check("reset_pix_ready", int'(if_f.pix_ready), 0);
    check("reset_object_image", int'(if_f.object_image), 0);
    check("reset_frame_done", int'(done_f_sig), 0);
    @(posedge clk); #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    check("idle_pix_ready", int'(if_f.pix_ready), 0);

    // All skin, full-rate, with a start pulse mid-frame that must be ignored.
    fill_image(0); clear_stats(); push_frame();
    drive_frame(1'b0, -1, -1, 50, ok);
    check("A_drive_ok", int'(ok), 1);
    if (!ok) finish_report();
    wait_done("A");
    check("A_ones_filtered", ones_f, W * H);
    check("A_ones_raw", ones_r, W * H);
    check("A_sof_count", n_sof, 1);
    check("A_eol_count", n_eol, H);

    // Single isolated skin pixel at (5,10).
    fill_image(1); clear_stats(); push_frame();
    drive_frame(1'b0, -1, -1, -1, ok);
    check("B_drive_ok", int'(ok), 1);
    if (!ok) finish_report();
    wait_done("B");
    check("B_ones_filtered", ones_f, 0);
    check("B_ones_raw", ones_r, 1);
    check("B_raw_at_5_10", int'(got_r[5][10]), 1);

    // Reset in the middle of row 37.
    fill_image(2); clear_stats(); push_frame();
    drive_frame(1'b0, 37, 50, -1, ok);
    check("C_drive_ok", int'(ok), 1);
    if (!ok) finish_report();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("C_post_rst_obj_valid_f", int'(if_f.obj_valid), 0);
    check("C_post_rst_pix_ready_f", int'(if_f.pix_ready), 0);
    check("C_post_rst_obj_valid_r", int'(if_r.obj_valid), 0);
    check("C_post_rst_pix_ready_r", int'(if_r.pix_ready), 0);
    exp_q.delete();
    clear_stats();
    repeat (50) @(posedge clk);
    #1;
    check("C_no_frame_done", done_f + done_r, 0);
    check("C_no_output_idle", n_out, 0);

    // Random chroma, random pix_valid, obj_ready toggling, plus the vector table.
    fill_image(3); clear_stats(); push_frame();
    drive_frame(1'b1, -1, -1, -1, ok);
    check("D_drive_ok", int'(ok), 1);
    if (!ok) finish_report();
    wait_done("D");
    check("D_first_row", first_row, 0);
    check("D_first_col", first_col, 0);
    check("D_first_sof", first_sof, 1);
    check("D_ready_while_stalled", ready_viol, 0);
    for (int i = 0; i < 12; i++) begin
      check($sformatf("vec%0d_filtered_r%0d_c%0d", i, vecs[i].row, vecs[i].col),
            int'(got_f[vecs[i].row][vecs[i].col]), int'(vecs[i].filt));
      check($sformatf("vec%0d_raw_r%0d_c%0d", i, vecs[i].row, vecs[i].col),
            int'(got_r[vecs[i].row][vecs[i].col]), int'(vecs[i].raw));
    end

    finish_report();
  end

endmodule
